// File: rtl/iob_picorv32_bus_arbiter.sv
// iob_picorv32_bus_arbiter: merges the CPU instruction (m0) and data (m1) IOb buses onto one shared IOb port.
module iob_picorv32_bus_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int PRIORITY = 0
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,
    input  logic                  cke_i,
    input  logic                  m0_avalid_i,
    input  logic [ADDR_W-1:0]     m0_addr_i,
    input  logic [DATA_W-1:0]     m0_wdata_i,
    input  logic [DATA_W/8-1:0]   m0_wstrb_i,
    output logic [DATA_W-1:0]     m0_rdata_o,
    output logic                  m0_rvalid_o,
    output logic                  m0_ready_o,
    input  logic                  m1_avalid_i,
    input  logic [ADDR_W-1:0]     m1_addr_i,
    input  logic [DATA_W-1:0]     m1_wdata_i,
    input  logic [DATA_W/8-1:0]   m1_wstrb_i,
    output logic [DATA_W-1:0]     m1_rdata_o,
    output logic                  m1_rvalid_o,
    output logic                  m1_ready_o,
    output logic                  s_avalid_o,
    output logic [ADDR_W-1:0]     s_addr_o,
    output logic [DATA_W-1:0]     s_wdata_o,
    output logic [DATA_W/8-1:0]   s_wstrb_o,
    input  logic [DATA_W-1:0]     s_rdata_i,
    input  logic                  s_rvalid_i,
    input  logic                  s_ready_i
);
    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t state, state_nxt;
    logic lock, lock_nxt, lock_owner, lock_owner_nxt;
    logic rr_last, rr_last_nxt, rd_owner, rd_owner_nxt;
    logic win, grant, rd_route;
    logic [DATA_W/8-1:0] win_wstrb;

    always_comb begin
        // A held grant beats any new arbitration so a stalled request is never swapped out
        win = lock ? lock_owner
            : (m0_avalid_i ^ m1_avalid_i) ? m1_avalid_i
            : (PRIORITY != 0) ? 1'b0 : ~rr_last;
        grant = (state == IDLE) & (win ? m1_avalid_i : m0_avalid_i);
        win_wstrb = win ? m1_wstrb_i : m0_wstrb_i;
        s_avalid_o = grant;
        s_addr_o = grant ? (win ? m1_addr_i : m0_addr_i) : '0;
        s_wdata_o = grant ? (win ? m1_wdata_i : m0_wdata_i) : '0;
        s_wstrb_o = grant ? win_wstrb : '0;
        m0_ready_o = grant & ~win & s_ready_i;
        m1_ready_o = grant & win & s_ready_i;
        rd_route = (state == RD_WAIT);
        m0_rdata_o = (rd_route & ~rd_owner) ? s_rdata_i : '0;
        m1_rdata_o = (rd_route & rd_owner) ? s_rdata_i : '0;
        m0_rvalid_o = rd_route & ~rd_owner & s_rvalid_i;
        m1_rvalid_o = rd_route & rd_owner & s_rvalid_i;
        state_nxt = state;
        lock_nxt = lock;
        lock_owner_nxt = lock_owner;
        rr_last_nxt = rr_last;
        rd_owner_nxt = rd_owner;
        if (state == RD_WAIT) begin
            if (s_rvalid_i) state_nxt = IDLE;
        end else if (grant & s_ready_i) begin
            lock_nxt = 1'b0;
            rr_last_nxt = win;
            if (win_wstrb == '0) begin
                state_nxt = RD_WAIT;
                rd_owner_nxt = win;
            end
        end else begin
            lock_nxt = grant;
            lock_owner_nxt = win;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state <= IDLE;
            lock <= 1'b0;
            lock_owner <= 1'b0;
            rr_last <= 1'b1;
            rd_owner <= 1'b0;
        end else if (cke_i) begin
            state <= state_nxt;
            lock <= lock_nxt;
            lock_owner <= lock_owner_nxt;
            rr_last <= rr_last_nxt;
            rd_owner <= rd_owner_nxt;
        end
    end
endmodule

// File: tb/tb_iob_picorv32_bus_arbiter.sv
// tb_iob_picorv32_bus_arbiter: directed and randomized checks of both arbitration modes side by side.
module tb_iob_picorv32_bus_arbiter;
    logic clk = 0, arst_n = 0, cke = 1;
    always #5 clk = ~clk;

    logic        m0_avalid, m1_avalid, s_rvalid, s_ready;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, s_rdata;
    logic [3:0]  m0_wstrb, m1_wstrb;

    logic        s_avalid [2], m0_ready [2], m1_ready [2], m0_rvalid [2], m1_rvalid [2];
    logic [31:0] s_addr [2], s_wdata [2], m0_rdata [2], m1_rdata [2];
    logic [3:0]  s_wstrb [2];

    int checks = 0, failures = 0;

    // Instance 0 is round-robin, instance 1 is fixed priority; both see identical stimulus
    for (genvar p = 0; p < 2; p++) begin : g_dut
        iob_picorv32_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIORITY(p)) dut (
            .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke),
            .m0_avalid_i(m0_avalid), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata), .m0_wstrb_i(m0_wstrb),
            .m0_rdata_o(m0_rdata[p]), .m0_rvalid_o(m0_rvalid[p]), .m0_ready_o(m0_ready[p]),
            .m1_avalid_i(m1_avalid), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_wstrb_i(m1_wstrb),
            .m1_rdata_o(m1_rdata[p]), .m1_rvalid_o(m1_rvalid[p]), .m1_ready_o(m1_ready[p]),
            .s_avalid_o(s_avalid[p]), .s_addr_o(s_addr[p]), .s_wdata_o(s_wdata[p]), .s_wstrb_o(s_wstrb[p]),
            .s_rdata_i(s_rdata), .s_rvalid_i(s_rvalid), .s_ready_i(s_ready)
        );
    end

    task automatic idle_inputs();
        m0_avalid = 0; m1_avalid = 0; m0_addr = 0; m1_addr = 0;
        m0_wdata = 0; m1_wdata = 0; m0_wstrb = 0; m1_wstrb = 0;
        s_rdata = 0; s_rvalid = 0; s_ready = 0; cke = 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        arst_n = 0;
        repeat (2) @(negedge clk);
        arst_n = 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle_inputs();
        arst_n = 0;
        s_ready = 1; s_rvalid = 1; s_rdata = 32'hFFFF_FFFF;
        #1;
        for (int p = 0; p < 2; p++) begin
            checks++;
            if ({s_avalid[p], m0_ready[p], m1_ready[p], m0_rvalid[p], m1_rvalid[p], m0_rdata[p], m1_rdata[p]} !== '0) begin
                failures++;
                $display("FAIL reset_outputs p=%0d got av=%b r0=%b r1=%b v0=%b v1=%b d0=%h d1=%h want all 0", p,
                         s_avalid[p], m0_ready[p], m1_ready[p], m0_rvalid[p], m1_rvalid[p], m0_rdata[p], m1_rdata[p]);
            end
        end
        @(negedge clk);
        idle_inputs();
        arst_n = 1;
    endtask

    task automatic test_single_read();
        do_reset();
        @(negedge clk);
        m0_avalid = 1; m0_addr = 32'h100; m0_wstrb = 0; s_ready = 1;
        #1;
        for (int p = 0; p < 2; p++) begin
            checks++;
            if ({s_avalid[p], s_addr[p], m0_ready[p], m1_ready[p]} !== {1'b1, 32'h100, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL single_read_req p=%0d got av=%b addr=%h r0=%b r1=%b want 1 100 1 0", p, s_avalid[p], s_addr[p], m0_ready[p], m1_ready[p]);
            end
        end
        @(negedge clk);
        m0_avalid = 0; s_ready = 0;
        #1;
        for (int p = 0; p < 2; p++) begin
            checks++;
            if ({s_avalid[p], m0_rvalid[p], m1_rvalid[p]} !== 3'b000) begin
                failures++;
                $display("FAIL single_read_wait p=%0d got av=%b v0=%b v1=%b want 000", p, s_avalid[p], m0_rvalid[p], m1_rvalid[p]);
            end
        end
        @(negedge clk);
        s_rvalid = 1; s_rdata = 32'hDEAD_BEEF;
        #1;
        for (int p = 0; p < 2; p++) begin
            checks++;
            if ({m0_rvalid[p], m1_rvalid[p], m0_rdata[p], m1_rdata[p]} !== {2'b10, 32'hDEAD_BEEF, 32'h0}) begin
                failures++;
                $display("FAIL single_read_resp p=%0d got v0=%b v1=%b d0=%h d1=%h want 1 0 deadbeef 0", p, m0_rvalid[p], m1_rvalid[p], m0_rdata[p], m1_rdata[p]);
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_round_robin();
        logic [31:0] a;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            m0_avalid = 1; m1_avalid = 1; m0_wstrb = 0; m1_wstrb = 0;
            m0_addr = 32'h200 + 32'(i * 4); m1_addr = 32'h300 + 32'(i * 4);
            s_ready = 1; s_rvalid = 0;
            a = (i % 2) ? m1_addr : m0_addr;
            #1;
            checks++;
            if ({m1_ready[0], m0_ready[0], s_addr[0]} !== {((i % 2) ? 2'b10 : 2'b01), a}) begin
                failures++;
                $display("FAIL rr_grant i=%0d got r1=%b r0=%b addr=%h want grant m%0d addr=%h", i, m1_ready[0], m0_ready[0], s_addr[0], i % 2, a);
            end
            @(negedge clk);
            s_rvalid = 1; s_rdata = ~a;
            #1;
            checks++;
            if ({m1_rvalid[0], m0_rvalid[0], ((i % 2) ? m1_rdata[0] : m0_rdata[0])} !== {((i % 2) ? 2'b10 : 2'b01), ~a}) begin
                failures++;
                $display("FAIL rr_resp i=%0d got v1=%b v0=%b d=%h want m%0d data=%h", i, m1_rvalid[0], m0_rvalid[0],
                         (i % 2) ? m1_rdata[0] : m0_rdata[0], i % 2, ~a);
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_fixed_priority();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            m0_avalid = 1; m1_avalid = 1; m0_wstrb = 4'hF; m1_wstrb = 4'h3;
            m0_addr = 32'h1000 + 32'(i); m1_addr = 32'h2000 + 32'(i); s_ready = 1;
            #1;
            checks++;
            if ({m1_ready[1], m0_ready[1], s_addr[1]} !== {2'b01, m0_addr}) begin
                failures++;
                $display("FAIL fixed_prio i=%0d got r1=%b r0=%b addr=%h want 0 1 %h", i, m1_ready[1], m0_ready[1], s_addr[1], m0_addr);
            end
            checks++;
            if ({m1_ready[0], m0_ready[0]} !== ((i % 2) ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL rr_writes i=%0d got r1=%b r0=%b want m%0d", i, m1_ready[0], m0_ready[0], i % 2);
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_lock_stall();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            m1_avalid = (c < 4); m1_addr = 32'h40; m1_wstrb = 4'hF; m1_wdata = 32'h1234_5678;
            m0_avalid = (c >= 1); m0_addr = 32'h80; m0_wstrb = 0;
            s_ready = (c >= 3);
            #1;
            for (int p = 0; p < 2; p++) begin
                checks++;
                if ({s_addr[p], m1_ready[p], m0_ready[p]} !== {((c < 4) ? 32'h40 : 32'h80), c == 3, c == 4}) begin
                    failures++;
                    $display("FAIL lock_stall c=%0d p=%0d got addr=%h r1=%b r0=%b", c, p, s_addr[p], m1_ready[p], m0_ready[p]);
                end
            end
        end
        @(negedge clk);
        idle_inputs();
        s_rvalid = 1;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            m1_avalid = 1; m1_addr = 32'h10 + 32'(i * 4); m1_wstrb = 4'hF; m1_wdata = $urandom; s_ready = 1;
            #1;
            for (int p = 0; p < 2; p++) begin
                checks++;
                if ({m1_ready[p], s_avalid[p], s_addr[p], s_wstrb[p], s_wdata[p]} !== {2'b11, m1_addr, 4'hF, m1_wdata}) begin
                    failures++;
                    $display("FAIL b2b_write i=%0d p=%0d got r1=%b av=%b addr=%h strb=%h want 1 1 %h f", i, p, m1_ready[p], s_avalid[p], s_addr[p], s_wstrb[p], m1_addr);
                end
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset_in_rd_wait();
        do_reset();
        @(negedge clk);
        m0_avalid = 1; m0_addr = 32'h500; m0_wstrb = 0; s_ready = 1;
        @(negedge clk);
        idle_inputs();
        #3 arst_n = 0;
        s_rvalid = 1; s_rdata = 32'hA5A5_A5A5;
        #1;
        for (int p = 0; p < 2; p++) begin
            checks++;
            if ({m0_rvalid[p], m1_rvalid[p]} !== 2'b00) begin
                failures++;
                $display("FAIL rst_rd_during p=%0d got v0=%b v1=%b want 00", p, m0_rvalid[p], m1_rvalid[p]);
            end
        end
        @(negedge clk);
        arst_n = 1;
        #1;
        for (int p = 0; p < 2; p++) begin
            checks++;
            if ({m0_rvalid[p], m1_rvalid[p], m0_rdata[p]} !== 34'h0) begin
                failures++;
                $display("FAIL rst_rd_after p=%0d got v0=%b v1=%b d0=%h want 0 0 0", p, m0_rvalid[p], m1_rvalid[p], m0_rdata[p]);
            end
        end
        @(negedge clk);
        idle_inputs();
        m1_avalid = 1; m1_addr = 32'h60; m1_wstrb = 4'h1; s_ready = 1;
        #1;
        for (int p = 0; p < 2; p++) begin
            checks++;
            if (m1_ready[p] !== 1'b1) begin
                failures++;
                $display("FAIL rst_rd_idle p=%0d got r1=%b want 1", p, m1_ready[p]);
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    // Reference: each arbiter is either serving a read for one master, or free, possibly holding a stalled grant
    task automatic test_random();
        int rd [2], hold [2], last [2];
        int g;
        logic granted;
        logic [1:0] v, e_rdy, e_rv;
        logic [31:0] e_addr, e_wdata, e_d0, e_d1;
        logic [3:0] e_strb, g_strb;
        do_reset();
        for (int p = 0; p < 2; p++) begin rd[p] = -1; hold[p] = -1; last[p] = 1; end
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            m0_avalid = 1'($urandom_range(0, 1)); m1_avalid = 1'($urandom_range(0, 1));
            m0_addr = $urandom; m1_addr = $urandom; m0_wdata = $urandom; m1_wdata = $urandom;
            m0_wstrb = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
            m1_wstrb = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
            s_ready = 1'($urandom_range(0, 1)); s_rvalid = ($urandom_range(0, 2) == 0);
            s_rdata = $urandom; cke = ($urandom_range(0, 7) != 0);
            #1;
            v = {m1_avalid, m0_avalid};
            for (int p = 0; p < 2; p++) begin
                e_rdy = 0; e_rv = 0; e_addr = 0; e_wdata = 0; e_strb = 0; e_d0 = 0; e_d1 = 0;
                granted = 0; g = 0; g_strb = 0;
                if (rd[p] >= 0) begin
                    e_rv = s_rvalid ? 2'(1 << rd[p]) : 2'b00;
                    if (rd[p] == 0) e_d0 = s_rdata; else e_d1 = s_rdata;
                end else begin
                    if (hold[p] >= 0) g = hold[p];
                    else if (v == 2'b10) g = 1;
                    else if (v == 2'b11) g = (p == 1) ? 0 : 1 - last[p];
                    granted = v[g];
                    g_strb = g ? m1_wstrb : m0_wstrb;
                    if (granted) begin
                        e_addr = g ? m1_addr : m0_addr;
                        e_wdata = g ? m1_wdata : m0_wdata;
                        e_strb = g_strb;
                        e_rdy = s_ready ? 2'(1 << g) : 2'b00;
                    end
                end
                checks++;
                if ({s_avalid[p], s_addr[p], s_wdata[p], s_wstrb[p], m1_ready[p], m0_ready[p]} !== {granted, e_addr, e_wdata, e_strb, e_rdy}) begin
                    failures++;
                    $display("FAIL rand_req cyc=%0d p=%0d got av=%b addr=%h wd=%h st=%h rdy=%b%b want av=%b addr=%h wd=%h st=%h rdy=%b",
                             cyc, p, s_avalid[p], s_addr[p], s_wdata[p], s_wstrb[p], m1_ready[p], m0_ready[p], granted, e_addr, e_wdata, e_strb, e_rdy);
                end
                checks++;
                if ({m1_rvalid[p], m0_rvalid[p], m0_rdata[p], m1_rdata[p]} !== {e_rv, e_d0, e_d1}) begin
                    failures++;
                    $display("FAIL rand_resp cyc=%0d p=%0d got rv=%b%b d0=%h d1=%h want rv=%b d0=%h d1=%h",
                             cyc, p, m1_rvalid[p], m0_rvalid[p], m0_rdata[p], m1_rdata[p], e_rv, e_d0, e_d1);
                end
                if (cke) begin
                    if (rd[p] >= 0) begin
                        if (s_rvalid) rd[p] = -1;
                    end else if (granted && s_ready) begin
                        last[p] = g;
                        hold[p] = -1;
                        if (g_strb == 0) rd[p] = g;
                    end else begin
                        hold[p] = granted ? g : -1;
                    end
                end
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_fixed_priority();
        test_lock_stall();
        test_back_to_back();
        test_reset_in_rd_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
